// File: rtl/mem_arb_pkg.sv
// Shared defaults and FSM encoding for the instruction/data memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DFLT     = 16;
  localparam int DATA_W_DFLT     = 16;
  localparam int STARVE_MAX_DFLT = 3;

  // State names the access that is in its response cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RESP_IF = 2'b01,
    RESP_DM = 2'b10
  } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the requesters plus the memory.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of fetch losses; clear has priority over increment.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == CNT_MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch and data
// accesses: issue in one cycle, acknowledge with read data in the next.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DFLT,
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int STARVE_MAX = STARVE_MAX_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  arb_state_e        state_q, state_d;
  logic              load_q, load_d;
  logic              if_elig, dm_elig;
  logic              grant_if, grant_dm;
  logic              at_max;
  logic              if_ack, dm_ack;
  logic              issue_en, issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  // A requester in its own ack cycle still has req high and must not be re-granted.
  always_comb begin
    if_elig  = bus.if_req && (state_q != RESP_IF);
    dm_elig  = bus.dm_req && (state_q != RESP_DM);
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (!reset) begin
      if (if_elig && dm_elig) begin
        grant_if = at_max;
        grant_dm = !at_max;
      end else begin
        grant_if = if_elig;
        grant_dm = dm_elig;
      end
    end
  end

  always_comb begin
    state_d     = IDLE;
    load_d      = 1'b0;
    issue_en    = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    if (grant_dm) begin
      state_d     = RESP_DM;
      load_d      = !bus.dm_we;
      issue_en    = 1'b1;
      issue_we    = bus.dm_we;
      issue_addr  = bus.dm_addr;
      issue_wdata = bus.dm_wdata;
    end else if (grant_if) begin
      state_d    = RESP_IF;
      issue_en   = 1'b1;
      issue_addr = bus.if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (grant_dm && bus.if_req),
    .clr    (grant_if),
    .at_max (at_max)
  );

  // Everything is forced quiet while reset is high, including the in-flight ack.
  assign if_ack        = !reset && (state_q == RESP_IF);
  assign dm_ack        = !reset && (state_q == RESP_DM);
  assign bus.if_ack    = if_ack;
  assign bus.dm_ack    = dm_ack;
  assign bus.if_rdata  = if_ack ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (dm_ack && load_q) ? bus.mem_rdata : '0;
  assign bus.mem_en    = issue_en;
  assign bus.mem_we    = issue_we;
  assign bus.mem_addr  = issue_addr;
  assign bus.mem_wdata = issue_wdata;
  assign bus.stall     = !reset && ((bus.if_req && !if_ack) || (bus.dm_req && !dm_ack));
endmodule
